// File: rtl/superh16_alu_issue_arb.sv
// Integer ALU issue arbiter: grants up to NUM_ALU of NUM_REQ requesters per cycle,
// starved requesters first, then round-robin, into registered issue slots.
package superh16_alu_pkg;
  typedef logic [5:0] uop_opcode_t;
endpackage

// Per-requester wait counter; flags starvation once it saturates.
module superh16_alu_wait_ctr #(
  parameter int STARVE_LIMIT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       alu_stall,
  input  logic       req_valid,
  input  logic       req_ready,
  output logic [3:0] wait_cnt,
  output logic       starved
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       wait_cnt <= '0;
    else if (flush)                   wait_cnt <= '0;
    else if (alu_stall)               wait_cnt <= wait_cnt;
    else if (!req_valid || req_ready) wait_cnt <= '0;
    else if (wait_cnt != LIM)         wait_cnt <= wait_cnt + 4'd1;
  end

  assign starved = (wait_cnt == LIM);
endmodule

module superh16_alu_issue_arb
  import superh16_alu_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int NUM_ALU       = 2,
  parameter int STARVE_LIMIT  = 7,
  parameter int XLEN          = 32,
  parameter int PHYS_REG_BITS = 7,
  parameter int ROB_IDX_BITS  = 6
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         flush,
  input  logic                                         alu_stall,
  input  logic        [NUM_REQ-1:0]                    req_valid,
  input  uop_opcode_t [NUM_REQ-1:0]                    req_opcode,
  input  logic        [NUM_REQ-1:0][XLEN-1:0]          req_src1,
  input  logic        [NUM_REQ-1:0][XLEN-1:0]          req_src2,
  input  logic        [NUM_REQ-1:0][PHYS_REG_BITS-1:0] req_dst_tag,
  input  logic        [NUM_REQ-1:0][ROB_IDX_BITS-1:0]  req_rob_idx,
  output logic        [NUM_REQ-1:0]                    req_ready,
  output logic        [NUM_ALU-1:0]                    alu_valid,
  output uop_opcode_t [NUM_ALU-1:0]                    alu_opcode,
  output logic        [NUM_ALU-1:0][XLEN-1:0]          alu_src1,
  output logic        [NUM_ALU-1:0][XLEN-1:0]          alu_src2,
  output logic        [NUM_ALU-1:0][PHYS_REG_BITS-1:0] alu_dst_tag,
  output logic        [NUM_ALU-1:0][ROB_IDX_BITS-1:0]  alu_rob_idx,
  output logic        [31:0]                           issue_count
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]                rr_ptr, rr_nxt, idx;
  logic                         rr_upd;
  logic [NUM_REQ-1:0][3:0]      wait_cnt;
  logic [NUM_REQ-1:0]           starved;
  logic [NUM_ALU-1:0]           slot_vld;
  logic [NUM_ALU-1:0][PW-1:0]   slot_sel;
  int                           n_gnt;
  int                           j;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wait
    superh16_alu_wait_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .alu_stall (alu_stall),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .wait_cnt  (wait_cnt[g]),
      .starved   (starved[g])
    );
  end

  // Two passes fill slots in priority order: starved by index, then round-robin from rr_ptr.
  always_comb begin
    req_ready = '0;
    slot_vld  = '0;
    slot_sel  = '0;
    rr_upd    = 1'b0;
    rr_nxt    = rr_ptr;
    n_gnt     = 0;
    j         = 0;
    idx       = '0;
    if (rst_n && !flush && !alu_stall) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && starved[i] && n_gnt < NUM_ALU) begin
          for (int s = 0; s < NUM_ALU; s++)
            if (s == n_gnt) begin
              slot_vld[s] = 1'b1;
              slot_sel[s] = PW'(i);
            end
          req_ready[i] = 1'b1;
          n_gnt = n_gnt + 1;
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        idx = PW'(j);
        if (req_valid[idx] && !starved[idx] && !req_ready[idx] && n_gnt < NUM_ALU) begin
          for (int s = 0; s < NUM_ALU; s++)
            if (s == n_gnt) begin
              slot_vld[s] = 1'b1;
              slot_sel[s] = idx;
            end
          req_ready[idx] = 1'b1;
          n_gnt  = n_gnt + 1;
          rr_upd = 1'b1;
          rr_nxt = (j + 1 >= NUM_REQ) ? '0 : PW'(j + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid   <= '0;
      alu_opcode  <= '0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      alu_dst_tag <= '0;
      alu_rob_idx <= '0;
      rr_ptr      <= '0;
      issue_count <= '0;
    end else if (flush) begin
      alu_valid <= '0;
    end else if (!alu_stall) begin
      alu_valid <= slot_vld;
      for (int s = 0; s < NUM_ALU; s++) begin
        alu_opcode[s]  <= req_opcode[slot_sel[s]];
        alu_src1[s]    <= req_src1[slot_sel[s]];
        alu_src2[s]    <= req_src2[slot_sel[s]];
        alu_dst_tag[s] <= req_dst_tag[slot_sel[s]];
        alu_rob_idx[s] <= req_rob_idx[slot_sel[s]];
      end
      if (rr_upd) rr_ptr <= rr_nxt;
      issue_count <= issue_count + 32'(n_gnt);
    end
  end
endmodule
